uart_cmd_rcv: RTL and testbench
===============================

UART_CMD_RCV -- requirements
Module: uart_cmd_rcv

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning max clk cycles allowed between bytes of one command.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port RX, input, 1, serial line (idle high), passed to the internal uart_rx.
REQ-005 SHALL have port clr_cmd_rdy, input, 1, consumer acknowledge of the current command.
REQ-006 SHALL have port cmd, output, 24, assembled command; byte0 in [23:16], byte1 in [15:8], byte2 in [7:0].
REQ-007 SHALL have port cmd_rdy, output, 1, high while a complete unacknowledged command is held.
REQ-008 SHALL have port timeout_err, output, 1, one-cycle pulse when a partial command is discarded on timeout.
REQ-009 SHALL have port overrun, output, 1, one-cycle pulse when a byte is dropped because cmd_rdy is high.

Function
REQ-010 SHALL instantiate one uart_rx (8N1, 43 clk/bit) and drive its clr_rdy combinationally high in every cycle its rdy is high; no byte remains pending in uart_rx for more than one cycle.
REQ-011 SHALL implement FSM states WAIT0, WAIT1, WAIT2, HOLD; reset state WAIT0.
REQ-012 In WAIT0, on rdy: SHALL load rx_data into cmd[23:16], clear the timeout counter, and go to WAIT1.
REQ-013 In WAIT1, on rdy: SHALL load rx_data into cmd[15:8], clear the timeout counter, and go to WAIT2.
REQ-014 In WAIT2, on rdy: SHALL load rx_data into cmd[7:0] and go to HOLD; cmd_rdy SHALL be high in the cycle after the third rdy (1-cycle latency).
REQ-015 In HOLD: cmd and cmd_rdy SHALL be held stable until clr_cmd_rdy is sampled high; cmd_rdy SHALL then be low in the next cycle, with the state at WAIT0.
REQ-016 In HOLD, rdy without clr_cmd_rdy: SHALL drop the byte, leave cmd unchanged, and pulse overrun for one cycle.
REQ-017 In HOLD, rdy and clr_cmd_rdy in the same cycle: SHALL load the byte into cmd[23:16], go to WAIT1, drop cmd_rdy next cycle, and not pulse overrun.
REQ-018 In WAIT1/WAIT2: the timeout counter SHALL increment each cycle without rdy; when it reaches TIMEOUT_CYCLES-1, the block SHALL go to WAIT0, pulse timeout_err next cycle, and leave cmd_rdy low.
REQ-019 rdy in the same cycle the counter hits TIMEOUT_CYCLES-1: SHALL accept the byte; no timeout.
REQ-020 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide, saturate-free, and held at 0 in WAIT0 and HOLD.
REQ-021 clr_cmd_rdy outside HOLD SHALL be ignored.
REQ-022 After a timeout or acknowledge, cmd SHALL retain its last value; only byte loads change it.

Reset
REQ-023 On rst_n low, SHALL asynchronously set: state WAIT0, cmd 24'h000000, cmd_rdy 0, timeout_err 0, overrun 0, counter 0; uart_rx SHALL be reset by the same rst_n.
REQ-024 Reset mid-command SHALL discard all partial bytes, with no pulse on timeout_err or overrun after release.

Structure
REQ-025 Package uart_cmd_pkg SHALL hold the FSM state enum (2-bit) and the constant CMD_BYTES = 3.
REQ-026 uart_rx SHALL be the sole sub-module; the FSM, byte registers and timeout counter SHALL live in uart_cmd_rcv.

Verification (bench TIMEOUT_CYCLES = 2000, 43 clk/bit)
REQ-027 Send bytes 8'hA5, 8'h3C, 8'h0F back-to-back -> cmd_rdy rises 1 cycle after third byte's rdy with cmd = 24'hA53C0F; it stays high until clr_cmd_rdy, then falls next cycle.
REQ-028 Send 8'h11, then idle 2500 cycles -> timeout_err pulses once, cmd_rdy stays 0; then send 8'h22, 8'h33, 8'h44 -> cmd = 24'h223344.
REQ-029 Complete 24'h010203, no ack, send 8'hFF -> overrun pulses once, cmd remains 24'h010203, cmd_rdy stays 1.
REQ-030 Complete 24'h010203; force clr_cmd_rdy high in the cycle of the next byte 8'h77's rdy, then send 8'h88, 8'h99 -> no overrun, cmd_rdy drops, then cmd = 24'h778899.
REQ-031 Assert rst_n low after 2 of 3 bytes; release; send 3 bytes 8'hDE, 8'hAD, 8'hBE -> all outputs 0 during reset, then cmd = 24'hDEADBE, no error pulses.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the three-byte UART command receiver.
package uart_cmd_pkg;

    localparam int CMD_BYTES = 3;

    typedef enum logic [1:0] {
        WAIT0 = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2,
        HOLD  = 2'd3
    } cmd_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its midpoint, flags a byte with rdy
// until clr_rdy is seen (a new byte takes priority over the clear).
module uart_rx #(
    parameter int CLKS_PER_BIT = 43
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t         state_reg;
    logic [1:0]        sync_reg;
    logic [BAUD_W-1:0] baud_reg;
    logic [2:0]        bit_reg;
    logic [7:0]        shift_reg;
    logic              rx_s;

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RX_IDLE;
            sync_reg  <= 2'b11;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rdy       <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], rx};
            if (clr_rdy) rdy <= 1'b0;
            case (state_reg)
                RX_IDLE: begin
                    baud_reg <= '0;
                    if (!rx_s) state_reg <= RX_START;
                end
                RX_START: begin
                    // Re-check at mid start bit so glitches do not start a frame
                    if (baud_reg == HALF_LAST) begin
                        baud_reg  <= '0;
                        bit_reg   <= '0;
                        state_reg <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                RX_DATA: begin
                    if (baud_reg == BIT_LAST) begin
                        baud_reg  <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_reg == 3'd7) state_reg <= RX_STOP;
                        else                 bit_reg   <= bit_reg + 3'd1;
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                default: begin
                    if (baud_reg == BIT_LAST) begin
                        baud_reg  <= '0;
                        state_reg <= RX_IDLE;
                        if (rx_s) begin
                            rx_data <= shift_reg;
                            rdy     <= 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_rcv.sv
// Assembles three UART bytes into a 24-bit command, with inter-byte timeout,
// consumer handshake and overrun reporting.
module uart_cmd_rcv
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    output logic        timeout_err,
    output logic        overrun
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    cmd_state_t           state_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [7:0]           rx_data;
    logic                 rx_rdy;
    logic [CMD_BYTES-1:0] byte_load;
    logic [7:0]           cmd_byte_reg [CMD_BYTES];

    // Every byte is consumed in the cycle it is flagged, so rdy never lingers
    uart_rx #(.CLKS_PER_BIT(43)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (RX),
        .clr_rdy (rx_rdy),
        .rx_data (rx_data),
        .rdy     (rx_rdy)
    );

    always_comb begin
        byte_load = '0;
        if (rx_rdy) begin
            case (state_reg)
                WAIT0:   byte_load[0] = 1'b1;
                WAIT1:   byte_load[1] = 1'b1;
                WAIT2:   byte_load[2] = 1'b1;
                default: byte_load[0] = clr_cmd_rdy;
            endcase
        end
    end

    for (genvar gi = 0; gi < CMD_BYTES; gi++) begin : g_byte
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)             cmd_byte_reg[gi] <= '0;
            else if (byte_load[gi]) cmd_byte_reg[gi] <= rx_data;
        end
        assign cmd[8*(CMD_BYTES-1-gi) +: 8] = cmd_byte_reg[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= WAIT0;
            count_reg   <= '0;
            cmd_rdy     <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
            case (state_reg)
                WAIT0: begin
                    count_reg <= '0;
                    if (rx_rdy) state_reg <= WAIT1;
                end
                WAIT1, WAIT2: begin
                    // A byte arriving on the last allowed cycle still wins
                    if (rx_rdy) begin
                        count_reg <= '0;
                        if (state_reg == WAIT1) begin
                            state_reg <= WAIT2;
                        end else begin
                            state_reg <= HOLD;
                            cmd_rdy   <= 1'b1;
                        end
                    end else if (count_reg == CNT_LAST) begin
                        count_reg   <= '0;
                        state_reg   <= WAIT0;
                        timeout_err <= 1'b1;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                default: begin
                    count_reg <= '0;
                    if (clr_cmd_rdy) begin
                        cmd_rdy   <= 1'b0;
                        state_reg <= rx_rdy ? WAIT1 : WAIT0;
                    end else if (rx_rdy) begin
                        overrun <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Self-checking bench for uart_cmd_rcv: directed table, corner sequences and
// randomized byte streams against a byte-level reference model.
module tb_uart_cmd_rcv;

    localparam int TMO = 2000;
    localparam int BIT = 43;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        timeout_err;
    logic        overrun;

    always #5 clk = ~clk;

    uart_cmd_rcv #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    int checks = 0;
    int errors = 0;
    int to_cnt = 0;
    int ov_cnt = 0;
    int wide_cnt = 0;
    logic to_prev = 1'b0;
    logic ov_prev = 1'b0;

    always @(posedge clk) begin
        if (timeout_err) to_cnt <= to_cnt + 1;
        if (overrun)     ov_cnt <= ov_cnt + 1;
        if ((timeout_err && to_prev) || (overrun && ov_prev)) wide_cnt <= wide_cnt + 1;
        to_prev <= timeout_err;
        ov_prev <= overrun;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            idle(BIT);
        end
        RX = 1'b1;
        idle(BIT);
    endtask

    task automatic wait_rdy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (dut.rx_rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [23:0] exp_cmd;
    } vec_t;

    vec_t vecs[4];
    bit   seen;
    int   base_to;
    int   base_ov;

    // Byte-level reference model state
    logic [23:0] cmd_m;
    int          nb;
    bit          held;
    int          exp_to;
    int          exp_ov;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 8'h0F, 24'hA53C0F};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 24'h00FF00};
        vecs[2] = '{8'h80, 8'h01, 8'h7E, 24'h80017E};
        vecs[3] = '{8'h55, 8'hAA, 8'hC3, 24'h55AAC3};

        idle(5);
        chk("reset_cmd", 32'(cmd), 32'h0);
        chk("reset_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("reset_timeout_err", 32'(timeout_err), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        idle(10);

        // Back-to-back command with exact cmd_rdy latency
        send_byte(8'hA5);
        send_byte(8'h3C);
        fork
            send_byte(8'h0F);
            begin
                wait_rdy(seen);
                chk("lat_rdy_seen", 32'(seen), 32'h1);
                chk("lat_cmd_rdy_in_rdy_cycle", 32'(cmd_rdy), 32'h0);
                @(negedge clk);
                chk("lat_cmd_rdy_next_cycle", 32'(cmd_rdy), 32'h1);
                chk("lat_cmd", 32'(cmd), 32'hA53C0F);
            end
        join
        idle(50);
        chk("hold_cmd_rdy", 32'(cmd_rdy), 32'h1);
        ack();
        chk("ack_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("ack_cmd_kept", 32'(cmd), 32'hA53C0F);

        for (int v = 0; v < 4; v++) begin
            send_byte(vecs[v].b0);
            send_byte(vecs[v].b1);
            send_byte(vecs[v].b2);
            chk($sformatf("vec%0d_cmd", v), 32'(cmd), 32'(vecs[v].exp_cmd));
            chk($sformatf("vec%0d_cmd_rdy", v), 32'(cmd_rdy), 32'h1);
            ack();
            chk($sformatf("vec%0d_ack_rdy", v), 32'(cmd_rdy), 32'h0);
            chk($sformatf("vec%0d_ack_cmd", v), 32'(cmd), 32'(vecs[v].exp_cmd));
        end

        // Timeout on a partial command, then recovery
        base_to = to_cnt;
        send_byte(8'h11);
        idle(2500);
        chk("tmo_pulses", 32'(to_cnt - base_to), 32'h1);
        chk("tmo_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("tmo_byte0_kept", 32'(cmd[23:16]), 32'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("tmo_recover_cmd", 32'(cmd), 32'h223344);
        chk("tmo_recover_rdy", 32'(cmd_rdy), 32'h1);
        chk("tmo_no_extra", 32'(to_cnt - base_to), 32'h1);
        ack();

        // Overrun while holding
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        base_ov = ov_cnt;
        send_byte(8'hFF);
        chk("ovr_pulses", 32'(ov_cnt - base_ov), 32'h1);
        chk("ovr_cmd", 32'(cmd), 32'h010203);
        chk("ovr_cmd_rdy", 32'(cmd_rdy), 32'h1);

        // Ack coinciding with the next byte's rdy
        base_ov = ov_cnt;
        fork
            send_byte(8'h77);
            begin
                wait_rdy(seen);
                chk("ackrdy_seen", 32'(seen), 32'h1);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                chk("ackrdy_cmd_rdy", 32'(cmd_rdy), 32'h0);
                chk("ackrdy_byte0", 32'(cmd), 32'h770203);
            end
        join
        send_byte(8'h88);
        send_byte(8'h99);
        chk("ackrdy_cmd", 32'(cmd), 32'h778899);
        chk("ackrdy_rdy", 32'(cmd_rdy), 32'h1);
        chk("ackrdy_no_ovr", 32'(ov_cnt - base_ov), 32'h0);
        ack();

        // Reset in the middle of a command
        send_byte(8'h12);
        send_byte(8'h34);
        base_to = to_cnt;
        base_ov = ov_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cmd", 32'(cmd), 32'h0);
        chk("rst_mid_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("rst_mid_tmo", 32'(timeout_err), 32'h0);
        chk("rst_mid_ovr", 32'(overrun), 32'h0);
        idle(10);
        rst_n = 1'b1;
        idle(2500);
        chk("rst_no_tmo", 32'(to_cnt - base_to), 32'h0);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        chk("rst_cmd", 32'(cmd), 32'hDEADBE);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h1);
        chk("rst_no_pulses", 32'((to_cnt - base_to) + (ov_cnt - base_ov)), 32'h0);
        ack();

        // Randomized byte stream against the byte-level model
        cmd_m  = 24'hDEADBE;
        nb     = 0;
        held   = 1'b0;
        exp_to = to_cnt;
        exp_ov = ov_cnt;
        for (int k = 0; k < 30; k++) begin
            bit         long_gap;
            logic [7:0] b;
            long_gap = ($urandom_range(0, 6) == 0);
            b = 8'($urandom);
            if (long_gap) idle(2100);
            else          idle($urandom_range(0, 300));
            if (long_gap && nb > 0 && !held) begin
                exp_to++;
                nb = 0;
            end
            if (held) begin
                exp_ov++;
            end else begin
                cmd_m[23 - 8*nb -: 8] = b;
                nb++;
                if (nb == 3) begin
                    held = 1'b1;
                    nb = 0;
                end
            end
            send_byte(b);
            chk($sformatf("rnd%0d_cmd", k), 32'(cmd), 32'(cmd_m));
            chk($sformatf("rnd%0d_cmd_rdy", k), 32'(cmd_rdy), 32'(held));
            chk($sformatf("rnd%0d_tmo", k), 32'(to_cnt), 32'(exp_to));
            chk($sformatf("rnd%0d_ovr", k), 32'(ov_cnt), 32'(exp_ov));
            if ($urandom_range(0, 3) < 2) begin
                ack();
                held = 1'b0;
                chk($sformatf("rnd%0d_ack", k), 32'(cmd_rdy), 32'h0);
            end
        end

        chk("pulse_width", 32'(wide_cnt), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
